multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle LEGv8-style control FSM: fetch/decode/exec/mem/wb sequencing.
// Define MCCTRL_MEM_TIMEOUT_EN to build the memory-wait watchdog and FAULT state.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] opcode,
   input  logic        mem_ready,
   input  logic        zero_flag,
   input  logic        cond_true,
   output logic        mem_req,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        alu_src,
   output logic        readreg2_control,
   output logic        update_sreg,
   output logic [1:0]  alu_op,
   output logic [2:0]  state,
   output logic        illegal,
   output logic        fault
);

   if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || (2 ** CNT_W) <= MEM_TIMEOUT) begin : g_bad_cfg
      $error("multicycle_control: illegal MEM_TIMEOUT/CNT_W");
   end

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_UNDEF, C_ALU, C_ALUS, C_IMM, C_IMMS, C_CMP, C_CMPI,
      C_LOAD, C_STORE, C_B, C_CBZ, C_CBNZ, C_BCOND
   } cls_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       rr2;
      logic       update_sreg;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   state_t state_q, state_d;
   cls_t   cls_q, cls_d, dec_cls;
   ctrl_t  c, co;

`ifdef MCCTRL_MEM_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // CMP/CMPI use dedicated encodings so they never alias SUBS/SUBIS
   always_comb begin
      dec_cls = C_UNDEF;
      unique casez (opcode)
         11'b10001011000, 11'b11001011000,
         11'b10001010000, 11'b10101010000: dec_cls = C_ALU;
         11'b10101011000, 11'b11101011000,
         11'b11101010000:                  dec_cls = C_ALUS;
         11'b1001000100?, 11'b1001001000?,
         11'b1101001000?, 11'b1011001000?,
         11'b1101000100?:                  dec_cls = C_IMM;
         11'b1011000100?, 11'b1111000100?,
         11'b1111001000?:                  dec_cls = C_IMMS;
         11'b11101011001:                  dec_cls = C_CMP;
         11'b1111001010?:                  dec_cls = C_CMPI;
         11'b11111000010, 11'b00111000010,
         11'b01111000010, 11'b10111000100: dec_cls = C_LOAD;
         11'b11111000000, 11'b00111000000,
         11'b01111000000, 11'b10111000000: dec_cls = C_STORE;
         11'b000101?????:                  dec_cls = C_B;
         11'b10110100???:                  dec_cls = C_CBZ;
         11'b10110101???:                  dec_cls = C_CBNZ;
         11'b01010100???:                  dec_cls = C_BCOND;
         default:                          dec_cls = C_UNDEF;
      endcase
   end

   always_comb begin
      c       = '0;
      state_d = state_q;
      cls_d   = cls_q;
`ifdef MCCTRL_MEM_TIMEOUT_EN
      cnt_d   = '0;
`endif
      unique case (state_q)
         S_FETCH: begin
            c.mem_req  = 1'b1;
            c.mem_read = 1'b1;
            if (mem_ready) begin
               c.ir_write = 1'b1;
               c.pc_write = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            cls_d = dec_cls;
            if (dec_cls == C_UNDEF) begin
               c.illegal = 1'b1;
               state_d   = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            unique case (cls_q)
               C_ALU, C_ALUS: begin
                  c.alu_op = 2'b10;
                  state_d  = S_WB;
               end
               C_IMM, C_IMMS: begin
                  c.alu_src = 1'b1;
                  c.alu_op  = 2'b10;
                  state_d   = S_WB;
               end
               C_CMP, C_CMPI: begin
                  c.alu_op      = 2'b10;
                  c.update_sreg = 1'b1;
                  c.alu_src     = (cls_q == C_CMPI);
               end
               C_LOAD, C_STORE: begin
                  c.alu_src = 1'b1;
                  c.rr2     = (cls_q == C_STORE);
                  state_d   = S_MEM;
               end
               C_B: begin
                  c.pc_write = 1'b1;
                  c.pc_src   = 2'b01;
                  c.alu_op   = 2'b01;
               end
               C_CBZ, C_CBNZ: begin
                  c.rr2    = 1'b1;
                  c.alu_op = 2'b01;
                  if (zero_flag == (cls_q == C_CBZ)) begin
                     c.pc_write = 1'b1;
                     c.pc_src   = 2'b01;
                  end
               end
               C_BCOND: begin
                  c.alu_op = 2'b01;
                  if (cond_true) begin
                     c.pc_write = 1'b1;
                     c.pc_src   = 2'b01;
                  end
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            c.mem_req   = 1'b1;
            c.mem_read  = (cls_q == C_LOAD);
            c.mem_write = (cls_q == C_STORE);
            if (mem_ready) begin
               state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            c.reg_write   = 1'b1;
            c.mem_to_reg  = (cls_q == C_LOAD);
            c.update_sreg = (cls_q == C_ALUS) || (cls_q == C_IMMS);
            state_d       = S_FETCH;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FETCH;
      endcase
`ifdef MCCTRL_MEM_TIMEOUT_EN
      // a stalled request holds its state, so only stalls advance the count
      if (c.mem_req && !mem_ready) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == CNT_W'(MEM_TIMEOUT)) begin
            state_d = S_FAULT;
            cnt_d   = '0;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cls_q   <= C_UNDEF;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
      end
   end

`ifdef MCCTRL_MEM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
   assign fault = rst_n && (state_q == S_FAULT);
`else
   assign fault = 1'b0;
`endif

   assign co               = rst_n ? c : '0;
   assign state            = rst_n ? state_q : S_FETCH;
   assign mem_req          = co.mem_req;
   assign mem_read         = co.mem_read;
   assign mem_write        = co.mem_write;
   assign ir_write         = co.ir_write;
   assign pc_write         = co.pc_write;
   assign pc_src           = co.pc_src;
   assign reg_write        = co.reg_write;
   assign mem_to_reg       = co.mem_to_reg;
   assign alu_src          = co.alu_src;
   assign readreg2_control = co.rr2;
   assign update_sreg      = co.update_sreg;
   assign alu_op           = co.alu_op;
   assign illegal          = co.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output vectors.
// Fault checks follow MCCTRL_MEM_TIMEOUT_EN when the bench is built with it.
module tb_multicycle_control;

   typedef struct packed {
      logic [2:0] st;
      logic [4:0] m;
      logic [1:0] pcs;
      logic [4:0] d;
      logic [1:0] aop;
      logic [1:0] f;
   } ov_t;

   typedef struct {
      string nm;
      ov_t   e;
   } exp_t;

   // m = mem_req,mem_read,mem_write,ir_write,pc_write
   // d = reg_write,mem_to_reg,alu_src,readreg2,update_sreg ; f = illegal,fault
   localparam ov_t RST     = {3'd0, 5'b00000, 2'b00, 5'b00000, 2'b00, 2'b00};
   localparam ov_t F_WAIT  = {3'd0, 5'b11000, 2'b00, 5'b00000, 2'b00, 2'b00};
   localparam ov_t F_GO    = {3'd0, 5'b11011, 2'b00, 5'b00000, 2'b00, 2'b00};
   localparam ov_t DEC     = {3'd1, 5'b00000, 2'b00, 5'b00000, 2'b00, 2'b00};
   localparam ov_t DEC_ILL = {3'd1, 5'b00000, 2'b00, 5'b00000, 2'b00, 2'b10};
   localparam ov_t EX_ALU  = {3'd2, 5'b00000, 2'b00, 5'b00000, 2'b10, 2'b00};
   localparam ov_t EX_IMM  = {3'd2, 5'b00000, 2'b00, 5'b00100, 2'b10, 2'b00};
   localparam ov_t EX_CMP  = {3'd2, 5'b00000, 2'b00, 5'b00001, 2'b10, 2'b00};
   localparam ov_t EX_CMPI = {3'd2, 5'b00000, 2'b00, 5'b00101, 2'b10, 2'b00};
   localparam ov_t EX_LD   = {3'd2, 5'b00000, 2'b00, 5'b00100, 2'b00, 2'b00};
   localparam ov_t EX_ST   = {3'd2, 5'b00000, 2'b00, 5'b00110, 2'b00, 2'b00};
   localparam ov_t EX_B    = {3'd2, 5'b00001, 2'b01, 5'b00000, 2'b01, 2'b00};
   localparam ov_t EX_CB_T = {3'd2, 5'b00001, 2'b01, 5'b00010, 2'b01, 2'b00};
   localparam ov_t EX_CB_N = {3'd2, 5'b00000, 2'b00, 5'b00010, 2'b01, 2'b00};
   localparam ov_t EX_BC_T = {3'd2, 5'b00001, 2'b01, 5'b00000, 2'b01, 2'b00};
   localparam ov_t EX_BC_N = {3'd2, 5'b00000, 2'b00, 5'b00000, 2'b01, 2'b00};
   localparam ov_t MEM_LD  = {3'd3, 5'b11000, 2'b00, 5'b00000, 2'b00, 2'b00};
   localparam ov_t MEM_ST  = {3'd3, 5'b10100, 2'b00, 5'b00000, 2'b00, 2'b00};
   localparam ov_t WB_ALU  = {3'd4, 5'b00000, 2'b00, 5'b10000, 2'b00, 2'b00};
   localparam ov_t WB_ALUS = {3'd4, 5'b00000, 2'b00, 5'b10001, 2'b00, 2'b00};
   localparam ov_t WB_LD   = {3'd4, 5'b00000, 2'b00, 5'b11000, 2'b00, 2'b00};
   localparam ov_t FLT     = {3'd5, 5'b00000, 2'b00, 5'b00000, 2'b00, 2'b01};

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_ADDI = 11'b10010001001;
   localparam logic [10:0] OP_ANDS = 11'b11110010000;
   localparam logic [10:0] OP_CMP  = 11'b11101011001;
   localparam logic [10:0] OP_CMPI = 11'b11110010101;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_LDB  = 11'b00111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_B    = 11'b00010111111;
   localparam logic [10:0] OP_CBZ  = 11'b10110100000;
   localparam logic [10:0] OP_CBNZ = 11'b10110101010;
   localparam logic [10:0] OP_BC   = 11'b01010100101;
   localparam logic [10:0] OP_BAD  = 11'b00000000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] opcode = '0;
   logic        mem_ready = 1'b0;
   logic        zero_flag = 1'b0;
   logic        cond_true = 1'b0;
   logic        mem_req, mem_read, mem_write, ir_write, pc_write;
   logic [1:0]  pc_src, alu_op;
   logic        reg_write, mem_to_reg, alu_src, readreg2_control, update_sreg;
   logic [2:0]  state;
   logic        illegal, fault;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .zero_flag(zero_flag), .cond_true(cond_true),
      .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
      .readreg2_control(readreg2_control), .update_sreg(update_sreg),
      .alu_op(alu_op), .state(state), .illegal(illegal), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic cyc(input string nm, input logic rn, input logic [10:0] op,
                      input logic mr, input logic zf, input logic ct,
                      input ov_t e);
      exp_t x;
      @(posedge clk);
      #1;
      rst_n     = rn;
      opcode    = op;
      mem_ready = mr;
      zero_flag = zf;
      cond_true = ct;
      x.nm = nm;
      x.e  = e;
      sb.push_back(x);
   endtask

   task automatic fetch_go(input string nm, input logic [10:0] op);
      cyc({nm, "_f"}, 1'b1, op, 1'b1, 1'b0, 1'b0, F_GO);
      cyc({nm, "_d"}, 1'b1, op, 1'b1, 1'b0, 1'b0, DEC);
   endtask

   initial begin : monitor
      exp_t x;
      ov_t  a;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            x = sb.pop_front();
            a = {state, mem_req, mem_read, mem_write, ir_write, pc_write,
                 pc_src, reg_write, mem_to_reg, alu_src, readreg2_control,
                 update_sreg, alu_op, illegal, fault};
            n_cmp++;
            if (a !== x.e) begin
               n_bad++;
               $display("FAIL %s: got %b required %b", x.nm, a, x.e);
            end
         end
      end
   end

   initial begin : stim
      cyc("rst0", 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, RST);
      cyc("rst1", 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, RST);

      fetch_go("add", OP_ADD);
      cyc("add_ex", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, EX_ALU);
      cyc("add_wb", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, WB_ALU);

      fetch_go("ldur", OP_LDUR);
      cyc("ldur_ex", 1'b1, OP_LDUR, 1'b0, 1'b0, 1'b0, EX_LD);
      for (int i = 0; i < 3; i++)
         cyc("ldur_memw", 1'b1, OP_LDUR, 1'b0, 1'b0, 1'b0, MEM_LD);
      cyc("ldur_mem", 1'b1, OP_LDUR, 1'b1, 1'b0, 1'b0, MEM_LD);
      cyc("ldur_wb", 1'b1, OP_LDUR, 1'b0, 1'b0, 1'b0, WB_LD);

      fetch_go("cbz1", OP_CBZ);
      cyc("cbz1_ex", 1'b1, OP_CBZ, 1'b1, 1'b1, 1'b0, EX_CB_T);
      fetch_go("cbz0", OP_CBZ);
      cyc("cbz0_ex", 1'b1, OP_CBZ, 1'b1, 1'b0, 1'b0, EX_CB_N);
      fetch_go("cbnz0", OP_CBNZ);
      cyc("cbnz0_ex", 1'b1, OP_CBNZ, 1'b1, 1'b0, 1'b0, EX_CB_T);
      fetch_go("cbnz1", OP_CBNZ);
      cyc("cbnz1_ex", 1'b1, OP_CBNZ, 1'b1, 1'b1, 1'b0, EX_CB_N);

      cyc("ill_f", 1'b1, OP_BAD, 1'b1, 1'b0, 1'b0, F_GO);
      cyc("ill_d", 1'b1, OP_BAD, 1'b1, 1'b0, 1'b0, DEC_ILL);

      fetch_go("addi", OP_ADDI);
      cyc("addi_ex", 1'b1, OP_ADDI, 1'b1, 1'b0, 1'b0, EX_IMM);
      cyc("addi_wb", 1'b1, OP_ADDI, 1'b1, 1'b0, 1'b0, WB_ALU);
      fetch_go("subs", OP_SUBS);
      cyc("subs_ex", 1'b1, OP_SUBS, 1'b1, 1'b0, 1'b0, EX_ALU);
      cyc("subs_wb", 1'b1, OP_SUBS, 1'b1, 1'b0, 1'b0, WB_ALUS);
      fetch_go("andis", OP_ANDS);
      cyc("andis_ex", 1'b1, OP_ANDS, 1'b1, 1'b0, 1'b0, EX_IMM);
      cyc("andis_wb", 1'b1, OP_ANDS, 1'b1, 1'b0, 1'b0, WB_ALUS);
      fetch_go("cmp", OP_CMP);
      cyc("cmp_ex", 1'b1, OP_CMP, 1'b1, 1'b0, 1'b0, EX_CMP);
      fetch_go("cmpi", OP_CMPI);
      cyc("cmpi_ex", 1'b1, OP_CMPI, 1'b1, 1'b0, 1'b0, EX_CMPI);
      fetch_go("b", OP_B);
      cyc("b_ex", 1'b1, OP_B, 1'b1, 1'b0, 1'b0, EX_B);
      fetch_go("bc1", OP_BC);
      cyc("bc1_ex", 1'b1, OP_BC, 1'b1, 1'b0, 1'b1, EX_BC_T);
      fetch_go("bc0", OP_BC);
      cyc("bc0_ex", 1'b1, OP_BC, 1'b1, 1'b0, 1'b0, EX_BC_N);

      fetch_go("ldb", OP_LDB);
      cyc("ldb_ex", 1'b1, OP_LDB, 1'b1, 1'b0, 1'b0, EX_LD);
      cyc("ldb_mem", 1'b1, OP_LDB, 1'b1, 1'b0, 1'b0, MEM_LD);
      cyc("ldb_wb", 1'b1, OP_LDB, 1'b1, 1'b0, 1'b0, WB_LD);

      fetch_go("stur", OP_STUR);
      cyc("stur_ex", 1'b1, OP_STUR, 1'b0, 1'b0, 1'b0, EX_ST);
      cyc("stur_mem", 1'b1, OP_STUR, 1'b0, 1'b0, 1'b0, MEM_ST);
      cyc("stur_rst", 1'b0, OP_STUR, 1'b0, 1'b0, 1'b0, RST);
      cyc("stur_rel", 1'b1, OP_STUR, 1'b0, 1'b0, 1'b0, F_WAIT);
      cyc("stur_f2", 1'b1, OP_STUR, 1'b0, 1'b0, 1'b0, F_WAIT);
      cyc("stur_f3", 1'b1, OP_STUR, 1'b0, 1'b0, 1'b0, F_WAIT);
`ifdef MCCTRL_MEM_TIMEOUT_EN
      cyc("to_f4", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, F_WAIT);
      cyc("to_flt0", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, FLT);
      cyc("to_flt1", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, FLT);
      cyc("to_flt2", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, FLT);
      cyc("to_rst", 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, RST);
      cyc("to_rel", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, F_WAIT);
`else
      for (int i = 0; i < 6; i++)
         cyc("nowdt_f", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, F_WAIT);
`endif
      fetch_go("end", OP_ADD);
      cyc("end_ex", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, EX_ALU);

      @(negedge clk);
      #1;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
